// File: rtl/bloco_controle_if.sv
// Control bundle between bloco_controle (master) and the polynomial datapath (slave).
// Carries the start request, every datapath control line and the status outputs.
interface bloco_controle_if;
    logic       start;
    logic       LX;
    logic       LH;
    logic       LS;
    logic [1:0] M0;
    logic [1:0] M1;
    logic [1:0] M2;
    logic       H;
    logic       busy;
    logic       done;
    logic [7:0] ops_count;

    modport master (
        input  start,
        output LX, LH, LS, M0, M1, M2, H, busy, done, ops_count
    );

    modport slave (
        output start,
        input  LX, LH, LS, M0, M1, M2, H, busy, done, ops_count
    );
endinterface

// File: rtl/bloco_controle.sv
// Moore FSM sequencing the datapath through resultado = (A*K + B)*K + C.
// Optional BLOCO_CONTROLE_DONE_HOLD_EN: DONE is held until the next start request.
module bloco_controle (
    input  logic               clk,
    input  logic               rst,
    bloco_controle_if.master   ctl,
    output logic [2:0]         state_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MUL_A = 3'd2;
    localparam logic [2:0] S_ADD_B = 3'd3;
    localparam logic [2:0] S_MUL_X = 3'd4;
    localparam logic [2:0] S_ADD_C = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0] state_q, state_d;
    logic [7:0] ops_q, ops_d;

    // start is only looked at in IDLE (and in DONE when the hold option is built in).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ctl.start) state_d = S_LOAD;
            S_LOAD:  state_d = S_MUL_A;
            S_MUL_A: state_d = S_ADD_B;
            S_ADD_B: state_d = S_MUL_X;
            S_MUL_X: state_d = S_ADD_C;
            S_ADD_C: state_d = S_DONE;
`ifdef BLOCO_CONTROLE_DONE_HOLD_EN
            S_DONE:  if (ctl.start) state_d = S_LOAD;
`else
            S_DONE:  state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Only the ADD_C -> DONE edge counts, so a held DONE is counted once.
    always_comb begin
        ops_d = ops_q;
        if (state_q == S_ADD_C) ops_d = ops_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ops_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        ctl.LX   = 1'b0;
        ctl.LH   = 1'b0;
        ctl.LS   = 1'b0;
        ctl.M0   = 2'b00;
        ctl.M1   = 2'b00;
        ctl.M2   = 2'b00;
        ctl.H    = 1'b0;
        ctl.busy = 1'b0;
        ctl.done = 1'b0;
        case (state_q)
            S_LOAD: begin
                ctl.LX   = 1'b1;
                ctl.busy = 1'b1;
            end
            S_MUL_A: begin
                ctl.M0   = 2'b01;
                ctl.M2   = 2'b01;
                ctl.M1   = 2'b01;
                ctl.H    = 1'b1;
                ctl.LH   = 1'b1;
                ctl.busy = 1'b1;
            end
            S_ADD_B: begin
                ctl.M0   = 2'b10;
                ctl.M2   = 2'b11;
                ctl.LH   = 1'b1;
                ctl.busy = 1'b1;
            end
            S_MUL_X: begin
                ctl.M2   = 2'b11;
                ctl.M1   = 2'b01;
                ctl.H    = 1'b1;
                ctl.LH   = 1'b1;
                ctl.busy = 1'b1;
            end
            S_ADD_C: begin
                ctl.M0   = 2'b11;
                ctl.M2   = 2'b11;
                ctl.LS   = 1'b1;
                ctl.busy = 1'b1;
            end
            S_DONE:  ctl.done = 1'b1;
            default: ;
        endcase
    end

    assign ctl.ops_count = ops_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_bloco_controle.sv
// Bench for bloco_controle: drives it together with a small datapath and checks
// each completed evaluation against a Horner reference computed with plain arithmetic.
module tb_bloco_controle;
    logic        clk;
    logic        rst;
    logic [2:0]  dbg_state;
    logic [15:0] a_in, b_in, c_in, k_in;
    logic [15:0] x_r, h_r, s_r;
    logic [15:0] m0_v, pa, pb, alu;
    int          cyc;
    int          total;
    int          bad;
    int          busy_len;
    logic        done_prev;
    logic [7:0]  ops_exp;
    logic [55:0] exp_q[$];

`ifdef BLOCO_CONTROLE_DONE_HOLD_EN
    localparam int   PERIOD = 6;
    localparam logic HOLD   = 1'b1;
`else
    localparam int   PERIOD = 7;
    localparam logic HOLD   = 1'b0;
`endif

    bloco_controle_if dp_if ();

    bloco_controle dut (
        .clk     (clk),
        .rst     (rst),
        .ctl     (dp_if),
        .state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // datapath driven by the control lines
    always_comb begin
        case (dp_if.M0)
            2'b00:   m0_v = 16'd0;
            2'b01:   m0_v = a_in;
            2'b10:   m0_v = b_in;
            default: m0_v = c_in;
        endcase
        case (dp_if.M2)
            2'b00:   pa = x_r;
            2'b01:   pa = m0_v;
            2'b10:   pa = s_r;
            default: pa = h_r;
        endcase
        case (dp_if.M1)
            2'b00:   pb = m0_v;
            2'b01:   pb = x_r;
            2'b10:   pb = s_r;
            default: pb = h_r;
        endcase
        alu = dp_if.H ? 16'(pa * pb) : 16'(pa + pb);
    end

    always_ff @(posedge clk) begin
        if (dp_if.LX) x_r <= k_in;
        if (dp_if.LH) h_r <= alu;
        if (dp_if.LS) s_r <= alu;
    end

    function automatic logic [15:0] horner(input logic [15:0] a, b, c, k);
        longint unsigned r;
        r = 64'(a) * 64'(k) + 64'(b);
        r = r * 64'(k) + 64'(c);
        return 16'(r);
    endfunction

    function automatic logic [12:0] ctl_vec();
        return {dp_if.LX, dp_if.LH, dp_if.LS, dp_if.M0, dp_if.M1, dp_if.M2,
                dp_if.H, dp_if.busy, dp_if.done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver: called #1 after a rising edge while the DUT is free to accept start
    task automatic run_ops(input int n, input logic [15:0] a, b, c, k,
                           input int pulse_off, input int gap);
        int s;
        a_in = a; b_in = b; c_in = c; k_in = k;
        dp_if.start = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            s = cyc;
            ops_exp = ops_exp + 8'd1;
            exp_q.push_back({horner(a, b, c, k), ops_exp, 32'(s + 5)});
            dp_if.start = (i < n - 1) || (pulse_off == 0);
            for (int j = 1; j < PERIOD; j++) begin
                @(posedge clk); #1;
                dp_if.start = (i < n - 1) || (j == pulse_off && j <= 4);
            end
        end
        dp_if.start = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            check("idle_outputs", 32'(ctl_vec()), HOLD ? 32'd1 : 32'd0);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [55:0] item;
        if (rst) begin
            busy_len  = 0;
            done_prev = 1'b0;
        end else begin
            if (dp_if.busy) busy_len++;
            if (dp_if.done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    item = exp_q.pop_front();
                    check("resultado", 32'(s_r), 32'(item[55:40]));
                    check("ops_count", 32'(dp_if.ops_count), 32'(item[39:32]));
                    check("done_cycle", 32'(cyc), item[31:0]);
                    check("busy_cycles", 32'(busy_len), 32'd5);
                end
                busy_len = 0;
            end
            done_prev = dp_if.done;
        end
    end

    initial begin
        total = 0; bad = 0; ops_exp = 8'd0;
        busy_len = 0; done_prev = 1'b0;
        a_in = 16'd0; b_in = 16'd0; c_in = 16'd0; k_in = 16'd0;
        dp_if.start = 1'b0;
        rst = 1'b1;
        #2;
        check("reset_outputs", 32'(ctl_vec()), 32'd0);
        check("reset_ops", 32'(dp_if.ops_count), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_ops(1, 16'd2, 16'd3, 16'd4, 16'd5, -1, 2);
        run_ops(1, 16'hFFFF, 16'd0, 16'd1, 16'd2, -1, 1);
        run_ops(1, 16'd2, 16'd3, 16'd4, 16'd5, 3, 2);
        run_ops(4, 16'(($urandom)), 16'(($urandom)), 16'(($urandom)), 16'(($urandom)), -1, 1);
        for (int i = 0; i < 20; i++)
            run_ops($urandom_range(1, 2), 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), $urandom_range(0, 5) - 1, $urandom_range(0, 3));

        // reset in the middle of a run, during ADD_B
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        a_in = 16'd7; b_in = 16'd8; c_in = 16'd9; k_in = 16'd10;
        dp_if.start = 1'b1;
        @(posedge clk); #1;
        dp_if.start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        ops_exp = 8'd0;
        check("midrun_reset_outputs", 32'(ctl_vec()), 32'd0);
        check("midrun_reset_ops", 32'(dp_if.ops_count), 32'(ops_exp));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_ops(1, 16'd7, 16'd8, 16'd9, 16'd10, -1, 1);

        // wrap: 255 more runs complete 256 since the reset
        for (int i = 0; i < 255; i++)
            run_ops(1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), -1, 0);
        @(negedge clk);
        check("ops_wrap", 32'(dp_if.ops_count), 32'(ops_exp));
        @(posedge clk); #1;
        run_ops(1, 16'd1, 16'd1, 16'd1, 16'd1, -1, 3);

        repeat (10) @(posedge clk);
        check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
